// File: rtl/prog_launch_ctrl_pkg.sv
// Shared types and defaults for the program launch controller.
// Provides the FSM state enum, default widths/limits, the log-word layout
// and a helper that sizes index fields.
package prog_launch_ctrl_pkg;

  localparam int DEF_NUM_PROGS = 3;
  localparam int DEF_CNT_W     = 16;
  localparam int DEF_TIMEOUT   = 4096;

  typedef enum logic [2:0] {
    IDLE,
    RST,
    PULSE,
    WAIT,
    LOG,
    DONE
  } launch_state_t;

  // One log entry: timeout flag above the latency count.
  typedef struct packed {
    logic                 to;
    logic [DEF_CNT_W-1:0] cycles;
  } log_word_t;

  // Bits needed to hold 0..n-1; at least one bit so a single-entry index still has a width.
  function automatic int idx_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/prog_launch_ctrl_if.sv
// Bundle between a host and the launch controller: host controls, the core
// handshake and the log write port.
// Ports: req/abort/ack (host/core -> ctrl); core_reset/core_start/prog_sel (ctrl -> core);
//        log_we/log_addr/log_data (ctrl -> log); busy/done/any_timeout (ctrl status).
interface prog_launch_ctrl_if #(
  parameter int NUM_PROGS = prog_launch_ctrl_pkg::DEF_NUM_PROGS,
  parameter int CNT_W     = prog_launch_ctrl_pkg::DEF_CNT_W
);
  localparam int IW = prog_launch_ctrl_pkg::idx_w(NUM_PROGS);

  logic          req;
  logic          abort;
  logic          ack;
  logic          core_reset;
  logic          core_start;
  logic [IW-1:0] prog_sel;
  logic          log_we;
  logic [IW-1:0] log_addr;
  logic [CNT_W:0] log_data;
  logic          busy;
  logic          done;
  logic          any_timeout;

  // Host / core side.
  modport master (
    output req, abort, ack,
    input  core_reset, core_start, prog_sel, log_we, log_addr, log_data,
           busy, done, any_timeout
  );

  // Controller side.
  modport slave (
    input  req, abort, ack,
    output core_reset, core_start, prog_sel, log_we, log_addr, log_data,
           busy, done, any_timeout
  );

endinterface

// File: rtl/prog_launch_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear and enable; flags when it sits at MAX.
// Latency: count and at_max_o update one cycle after clr_i/en_i are sampled.
// Backpressure: none; clear has priority over enable.
// Ports: clk_i, rst_i (sync, active-high), clr_i, en_i, cnt_o, at_max_o.
module sat_counter #(
  parameter int          W   = 16,
  parameter int unsigned MAX = 4096
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         at_max_o
);
  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != MAX_V)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o    = cnt_q;
  assign at_max_o = (cnt_q == MAX_V);

endmodule

// File: rtl/prog_launch_ctrl.sv
// Runs NUM_PROGS programs on the core back to back: reset, start pulse, wait for Ack
// with a watchdog, then log {timeout, cycles}. All outputs are registered from next state.
// Backpressure: none; Ack is a level done flag, Abort cancels the batch from any state.
// Ports: clk_i, rst_i (sync, active-high), bus (slave modport of prog_launch_ctrl_if).
module prog_launch_ctrl
  import prog_launch_ctrl_pkg::*;
#(
  parameter int NUM_PROGS  = DEF_NUM_PROGS,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int TIMEOUT    = DEF_TIMEOUT,
  parameter int RST_CYCLES = 2,
  parameter int START_LEN  = 1
) (
  input logic               clk_i,
  input logic               rst_i,
  prog_launch_ctrl_if.slave bus
);
  localparam int IW = idx_w(NUM_PROGS);
  localparam int RW = idx_w(RST_CYCLES);
  localparam int SW = idx_w(START_LEN);

  launch_state_t  state_q, state_d;
  logic [IW-1:0]  idx_q;
  logic           core_reset_q, core_start_q, log_we_q, busy_q, done_q, any_to_q;
  logic [CNT_W:0] log_data_q;

  logic [CNT_W-1:0] cnt;
  logic             cnt_at_max, cnt_clr, cnt_en;
  logic [RW-1:0]    rst_ph;
  logic [SW-1:0]    start_ph;
  logic             rst_done, start_done, last_prog;
  logic             unused_phase;

  // Latency counter: zeroed on PULSE entry so the first WAIT cycle reads 1.
  assign cnt_clr = (state_d == PULSE) && (state_q != PULSE);
  assign cnt_en  = (state_q == PULSE) || (state_q == WAIT);

  sat_counter #(.W(CNT_W), .MAX(TIMEOUT)) u_cnt (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(cnt_clr), .en_i(cnt_en),
    .cnt_o(cnt), .at_max_o(cnt_at_max)
  );

  // Phase timers sit at 0 outside their state and reach MAX on the last cycle of it.
  sat_counter #(.W(RW), .MAX(RST_CYCLES - 1)) u_rst_ph (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(state_q != RST), .en_i(1'b1),
    .cnt_o(rst_ph), .at_max_o(rst_done)
  );

  sat_counter #(.W(SW), .MAX(START_LEN - 1)) u_start_ph (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(state_q != PULSE), .en_i(1'b1),
    .cnt_o(start_ph), .at_max_o(start_done)
  );

  // Only the at_max flags drive phase timing.
  assign unused_phase = ^{rst_ph, start_ph};

  assign last_prog = (idx_q == IW'(NUM_PROGS - 1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.req) state_d = RST;
      RST:     if (rst_done) state_d = PULSE;
      PULSE:   if (start_done) state_d = WAIT;
      WAIT:    if (bus.ack || cnt_at_max) state_d = LOG;
      LOG:     state_d = last_prog ? DONE : RST;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.abort) state_d = IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      core_reset_q <= 1'b0;
      core_start_q <= 1'b0;
      log_we_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      any_to_q     <= 1'b0;
      log_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      core_reset_q <= (state_d == RST);
      core_start_q <= (state_d == PULSE);
      log_we_q     <= (state_d == LOG);
      busy_q       <= (state_d != IDLE);
      done_q       <= (state_d == DONE);

      if ((state_q == IDLE) && (state_d == RST)) begin
        idx_q    <= '0;
        any_to_q <= 1'b0;
      end else if ((state_q == LOG) && (state_d == RST)) begin
        idx_q <= idx_q + 1'b1;
      end

      // Leaving WAIT without Ack can only mean the watchdog expired; Ack wins a tie.
      if ((state_q == WAIT) && (state_d == LOG)) begin
        log_data_q <= {~bus.ack, cnt};
        if (!bus.ack) any_to_q <= 1'b1;
      end
    end
  end

  assign bus.core_reset  = core_reset_q;
  assign bus.core_start  = core_start_q;
  assign bus.prog_sel    = idx_q;
  assign bus.log_we      = log_we_q;
  assign bus.log_addr    = idx_q;
  assign bus.log_data    = log_data_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.any_timeout = any_to_q;

endmodule

// File: tb/tb_prog_launch_ctrl.sv
// Directed bench for prog_launch_ctrl: one default instance and one with TIMEOUT=32,
// both driven by the same host stimulus and each answered by a small core model.
module tb_prog_launch_ctrl;
  import prog_launch_ctrl_pkg::*;

  localparam int NP  = 3;
  localparam int CW  = 16;
  localparam int TOB = 32;

  typedef struct packed {
    logic        cr, cs, we, busy, done, anyto;
    logic [1:0]  sel, addr;
    logic [16:0] data;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req = 1'b0, abort = 1'b0, ack_a = 1'b0, ack_b = 1'b0;

  always #5 clk = ~clk;

  prog_launch_ctrl_if #(.NUM_PROGS(NP), .CNT_W(CW)) ifa (), ifb ();

  assign ifa.req = req;  assign ifa.abort = abort;  assign ifa.ack = ack_a;
  assign ifb.req = req;  assign ifb.abort = abort;  assign ifb.ack = ack_b;

  prog_launch_ctrl dut_a (.clk_i(clk), .rst_i(rst), .bus(ifa));
  prog_launch_ctrl #(.TIMEOUT(TOB)) dut_b (.clk_i(clk), .rst_i(rst), .bus(ifb));

  obs_t pa, pb;
  assign pa = {ifa.core_reset, ifa.core_start, ifa.log_we, ifa.busy, ifa.done, ifa.any_timeout,
               ifa.prog_sel, ifa.log_addr, ifa.log_data};
  assign pb = {ifb.core_reset, ifb.core_start, ifb.log_we, ifb.busy, ifb.done, ifb.any_timeout,
               ifb.prog_sel, ifb.log_addr, ifb.log_data};

  obs_t        obs[2];
  int          cyc[2];
  int          ack_at[NP];     // cycles after the Start cycle at which the core acks; 0 = never
  logic        stuck = 1'b0;   // Ack held high regardless of the core
  int          nlog[2], ndone[2];
  logic [1:0]  la[2][8];
  logic [16:0] ld[2][8];
  int          vecs = 0, errs = 0;

  task automatic expect_eq(string tag, logic [31:0] got, logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] lw(logic t, int c);
    log_word_t w;
    w.to     = t;
    w.cycles = 16'(c);
    return w;
  endfunction

  // One clock: sample both DUTs after the edge, record logs, update the core models.
  task automatic tick();
    logic a;
    @(posedge clk);
    #1;
    obs[0] = pa;
    obs[1] = pb;
    for (int d = 0; d < 2; d++) begin
      if (obs[d].we) begin
        if (nlog[d] < 8) begin
          la[d][nlog[d]] = obs[d].addr;
          ld[d][nlog[d]] = obs[d].data;
        end
        nlog[d]++;
      end
      if (obs[d].done) ndone[d]++;
      if (obs[d].cr)          cyc[d] = -1;
      else if (obs[d].cs)     cyc[d] = 0;
      else if (cyc[d] >= 0)   cyc[d]++;
      a = stuck || (cyc[d] >= 0 && ack_at[obs[d].sel] != 0 && cyc[d] >= ack_at[obs[d].sel]);
      if (d == 0) ack_a = a;
      else        ack_b = a;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 1'b0; abort = 1'b0; stuck = 1'b0;
    cyc[0] = -1; cyc[1] = -1; ack_a = 1'b0; ack_b = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    nlog[0] = 0; nlog[1] = 0; ndone[0] = 0; ndone[1] = 0;
  endtask

  task automatic start_batch();
    req = 1'b1;
    tick();
    req = 1'b0;
  endtask

  task automatic wait_done(int want, int budget);
    int n = 0;
    while ((ndone[0] < want || ndone[1] < want) && n < budget) begin
      tick();
      n++;
    end
    expect_eq("done_cnt_a", ndone[0], want);
    expect_eq("done_cnt_b", ndone[1], want);
  endtask

  task automatic check_logs(string tag, int d, logic [16:0] e0, logic [16:0] e1, logic [16:0] e2);
    expect_eq($sformatf("%s_nlog%0d", tag, d), nlog[d], 3);
    expect_eq($sformatf("%s_addr0_%0d", tag, d), la[d][0], 0);
    expect_eq($sformatf("%s_addr1_%0d", tag, d), la[d][1], 1);
    expect_eq($sformatf("%s_addr2_%0d", tag, d), la[d][2], 2);
    expect_eq($sformatf("%s_data0_%0d", tag, d), ld[d][0], e0);
    expect_eq($sformatf("%s_data1_%0d", tag, d), ld[d][1], e1);
    expect_eq($sformatf("%s_data2_%0d", tag, d), ld[d][2], e2);
  endtask

  initial begin
    logic reached;
    int   n;
    for (int i = 0; i < NP; i++) ack_at[i] = 8;

    // 1) Reset: every output low on both instances.
    do_reset();
    for (int d = 0; d < 2; d++) begin
      expect_eq($sformatf("rst_outputs_%0d", d), obs[d], '0);
      expect_eq($sformatf("rst_busy_%0d", d), obs[d].busy, 0);
    end

    // 2) Core acks 7 cycles after Start drops -> 8 cycles logged per program.
    start_batch();
    expect_eq("t2_busy", obs[1].busy, 1);
    expect_eq("t2_core_reset", obs[1].cr, 1);
    wait_done(1, 200);
    for (int d = 0; d < 2; d++) begin
      check_logs("t2", d, lw(0, 8), lw(0, 8), lw(0, 8));
      expect_eq($sformatf("t2_anyto_%0d", d), obs[d].anyto, 0);
    end
    tick();
    expect_eq("t2_idle_busy", obs[1].busy, 0);

    // 3) Program 1 never acks: watchdog logs {1,TIMEOUT}; AnyTimeout sticky, cleared by next Req.
    do_reset();
    ack_at[1] = 0;
    start_batch();
    wait_done(1, 6000);
    check_logs("t3", 0, lw(0, 8), lw(1, DEF_TIMEOUT), lw(0, 8));
    check_logs("t3", 1, lw(0, 8), lw(1, TOB), lw(0, 8));
    expect_eq("t3_anyto_a", obs[0].anyto, 1);
    expect_eq("t3_anyto_b", obs[1].anyto, 1);
    ack_at[1] = 8;
    repeat (3) tick();
    expect_eq("t3_anyto_sticky", obs[1].anyto, 1);
    start_batch();
    expect_eq("t3_anyto_clr", obs[1].anyto, 0);

    // 4) Ack stuck high: nothing logged before WAIT, first WAIT cycle logs 1.
    do_reset();
    stuck = 1'b1;
    start_batch();
    repeat (3) tick();
    expect_eq("t4_no_early_log", nlog[1], 0);
    tick();
    expect_eq("t4_log_in_first_wait", obs[1].we, 1);
    wait_done(1, 100);
    check_logs("t4", 1, lw(0, 1), lw(0, 1), lw(0, 1));
    stuck = 1'b0;

    // 5) Abort in WAIT of program 1, then a fresh Req restarts at index 0.
    do_reset();
    start_batch();
    n = 0;
    reached = 1'b0;
    while (!reached && n < 200) begin
      tick();
      n++;
      reached = (nlog[1] == 1) && (obs[1].sel == 1) && (cyc[1] == 3);
    end
    expect_eq("t5_reach_wait", reached, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    for (int d = 0; d < 2; d++) begin
      expect_eq($sformatf("t5_busy_%0d", d), obs[d].busy, 0);
      expect_eq($sformatf("t5_core_start_%0d", d), obs[d].cs, 0);
      expect_eq($sformatf("t5_core_reset_%0d", d), obs[d].cr, 0);
    end
    repeat (40) tick();
    expect_eq("t5_no_more_log", nlog[1], 1);
    expect_eq("t5_no_done", ndone[1], 0);
    start_batch();
    expect_eq("t5_restart_sel", obs[1].sel, 0);
    n = 0;
    while (nlog[1] < 2 && n < 200) begin
      tick();
      n++;
    end
    expect_eq("t5_restart_addr", la[1][1], 0);
    expect_eq("t5_restart_data", ld[1][1], lw(0, 8));

    // 6) Req re-pulsed while Busy is ignored; Ack on the cnt==TIMEOUT cycle wins.
    do_reset();
    ack_at[1] = TOB;
    start_batch();
    repeat (5) tick();
    req = 1'b1;
    tick();
    req = 1'b0;
    wait_done(1, 600);
    for (int d = 0; d < 2; d++) begin
      check_logs("t6", d, lw(0, 8), lw(0, TOB), lw(0, 8));
      expect_eq($sformatf("t6_anyto_%0d", d), obs[d].anyto, 0);
    end
    repeat (10) tick();
    expect_eq("t6_idle_after", obs[1].busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
